// File: rtl/oled_spi_pkg.sv
// rtl/oled_spi_pkg.sv - shared constants and types for the OLED SPI receiver
// Purpose: PMOD pin indices, CPU register addresses, command codes, FIFO depth
//          and the command decoder state type.
// Ports:   none (package).
package oled_spi_pkg;

    localparam int PIN_SCK  = 1;
    localparam int PIN_MOSI = 2;
    localparam int PIN_CS_N = 3;
    localparam int PIN_DC   = 4;

    localparam logic [3:0] ADDR_FIFO     = 4'd0;
    localparam logic [3:0] ADDR_STATUS   = 4'd1;
    localparam logic [3:0] ADDR_PAGE     = 4'd2;
    localparam logic [3:0] ADDR_COLUMN   = 4'd3;
    localparam logic [3:0] ADDR_LAST_CMD = 4'd4;

    localparam logic [7:0] CMD_SET_PAGE = 8'h22;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        C_IDLE   = 2'd0,
        C_PSTART = 2'd1,
        C_PEND   = 2'd2
    } cmd_state_e;

endpackage

// File: rtl/tqvp_oled_spi_rx_if.sv
// rtl/tqvp_oled_spi_rx_if.sv - CPU register bus between host and OLED SPI receiver
// Purpose: groups the register-select / write-strobe / data signals.
// Signals: address[3:0], data_write, data_in[7:0] (host -> receiver),
//          data_out[7:0] (receiver -> host, combinational read data).
// Modports: master (host side), slave (receiver side).
interface tqvp_oled_spi_rx_if;

    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output address,
        output data_write,
        output data_in,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_write,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/oled_rx_fifo.sv
// rtl/oled_rx_fifo.sv - 4x8 byte FIFO with push, pop and flush
// Purpose: buffers received display data bytes for the CPU.
// Ports:   clk, rst (sync, active-high); push_i/push_data_i write side;
//          pop_i read side; flush_i empties the FIFO and wins over push/pop;
//          head_o raw head entry (qualify with empty_o), count_o, full_o, empty_o.
module oled_rx_fifo
    import oled_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output logic [7:0] head_o,
    output logic [2:0] count_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [2:0]    count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == 3'(FIFO_DEPTH));
    assign empty_o = (count_q == 3'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push on full is still taken.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 3'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + 3'(do_push) - 3'(do_pop);
        end
    end

endmodule

// File: rtl/tqvp_oled_spi_rx.sv
// rtl/tqvp_oled_spi_rx.sv - SPI mode-0 target capturing OLED command/data bytes
// Purpose: deserialises MOSI on SCK rising edges while CS_N is low; DC=1 bytes
//          go to a 4-entry FIFO, DC=0 bytes to last_cmd and (optionally) a
//          page/column tracking decoder.
// Ports:   clk, rst (sync, active-high); ui_in PMOD pins [1]SCK [2]MOSI
//          [3]CS_N [4]DC; uo_out tied low; bus = CPU register interface.
// Option:  OLED_RX_CMD_DECODE_EN enables the decoder FSM and page/column
//          counters; without it addr 2 and addr 3 read zero.
module tqvp_oled_spi_rx
    import oled_spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ui_in,
    output logic [7:0]        uo_out,
    tqvp_oled_spi_rx_if.slave bus
);

    logic       sck, mosi, cs_n, dc;
    logic       sck_q;
    logic       armed_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic [7:0] last_cmd_q;
    logic       overflow_q;
    logic [7:0] rx_byte_d;
    logic       sample, byte_done, data_push, push_drop;
    logic       pop_req, flush_req, ovf_clr;
    logic [7:0] fifo_head;
    logic [2:0] fifo_count;
    logic       fifo_full, fifo_empty;
    logic [7:0] page_rd, column_rd;
    logic       unused_ok;

    assign sck  = ui_in[PIN_SCK];
    assign mosi = ui_in[PIN_MOSI];
    assign cs_n = ui_in[PIN_CS_N];
    assign dc   = ui_in[PIN_DC];

    assign uo_out    = 8'h00;
    assign unused_ok = &{1'b0, ui_in[7:5], ui_in[0], bus.data_in[7:2]};

    // armed_q is only set while CS_N is high, so after a reset nothing is
    // received until the host deselects and reselects the target.
    assign sample    = sck && !sck_q && !cs_n && armed_q;
    assign rx_byte_d = {shift_q, mosi};
    assign byte_done = sample && (bit_cnt_q == 3'd7);
    assign data_push = byte_done && dc;

    assign pop_req   = bus.data_write && (bus.address == ADDR_FIFO);
    assign flush_req = bus.data_write && (bus.address == ADDR_STATUS) && bus.data_in[1];
    assign ovf_clr   = bus.data_write && (bus.address == ADDR_STATUS) && bus.data_in[0];
    assign push_drop = data_push && fifo_full && !pop_req && !flush_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q      <= 1'b0;
            armed_q    <= 1'b0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            last_cmd_q <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            sck_q <= sck;
            if (cs_n) begin
                armed_q   <= 1'b1;
                bit_cnt_q <= 3'd0;
                shift_q   <= 7'd0;
            end else if (sample) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= rx_byte_d[6:0];
            end
            if (byte_done && !dc) begin
                last_cmd_q <= rx_byte_d;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (push_drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    oled_rx_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (data_push),
        .push_data_i (rx_byte_d),
        .pop_i       (pop_req),
        .flush_i     (flush_req),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef OLED_RX_CMD_DECODE_EN
    cmd_state_e cmd_state_q;
    logic [2:0] page_q, page_start_q, page_end_q;
    logic [6:0] column_q;

    // Column/page advance on every received data byte, even if the FIFO drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_state_q  <= C_IDLE;
            page_q       <= 3'd0;
            page_start_q <= 3'd0;
            page_end_q   <= 3'd7;
            column_q     <= 7'd0;
        end else if (byte_done) begin
            if (!dc) begin
                unique case (cmd_state_q)
                    C_IDLE: begin
                        if (rx_byte_d == CMD_SET_PAGE) cmd_state_q <= C_PSTART;
                    end
                    C_PSTART: begin
                        page_start_q <= rx_byte_d[2:0];
                        page_q       <= rx_byte_d[2:0];
                        column_q     <= 7'd0;
                        cmd_state_q  <= C_PEND;
                    end
                    C_PEND: begin
                        page_end_q  <= rx_byte_d[2:0];
                        cmd_state_q <= C_IDLE;
                    end
                    default: cmd_state_q <= C_IDLE;
                endcase
            end else begin
                column_q <= column_q + 7'd1;
                if (column_q == 7'd127) begin
                    page_q <= (page_q == page_end_q) ? page_start_q : page_q + 3'd1;
                end
            end
        end
    end

    assign page_rd   = {5'b0, page_q};
    assign column_rd = {1'b0, column_q};
`else
    assign page_rd   = 8'h00;
    assign column_rd = 8'h00;
`endif

    always_comb begin
        bus.data_out = 8'h00;
        case (bus.address)
            ADDR_FIFO:     bus.data_out = fifo_empty ? 8'h00 : fifo_head;
            ADDR_STATUS:   bus.data_out = {overflow_q, ~cs_n, fifo_count, 3'b000};
            ADDR_PAGE:     bus.data_out = page_rd;
            ADDR_COLUMN:   bus.data_out = column_rd;
            ADDR_LAST_CMD: bus.data_out = last_cmd_q;
            default:       bus.data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_oled_spi_rx.sv
// tb/tb_tqvp_oled_spi_rx.sv - scoreboard bench for the OLED SPI receiver
module tb_tqvp_oled_spi_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck, mosi, cs_n, dc;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    tqvp_oled_spi_rx_if bus ();

    assign ui_in = {3'b000, dc, cs_n, mosi, sck, 1'b0};

    tqvp_oled_spi_rx dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [7:0] m_fifo[$];
    logic       m_ovf;
    logic [7:0] m_last;
    logic [2:0] m_pg, m_ps, m_pe;
    logic [6:0] m_col;
    int         m_cst;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ovf  = 1'b0;
        m_last = 8'h00;
        m_pg   = 3'd0;
        m_ps   = 3'd0;
        m_pe   = 3'd7;
        m_col  = 7'd0;
        m_cst  = 0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] v);
        bus.address = a;
        #1;
        v = bus.data_out;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        bus.address    = a;
        bus.data_in    = d;
        bus.data_write = 1'b1;
        tick();
        bus.data_write = 1'b0;
        bus.data_in    = 8'h00;
    endtask

    task automatic spi_bit(input logic b, input logic pop_same);
        sck  = 1'b0;
        mosi = b;
        tick();
        tick();
        sck = 1'b1;
        if (pop_same) begin
            bus.address    = 4'd0;
            bus.data_write = 1'b1;
        end
        tick();
        bus.data_write = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d, input logic pop_last = 1'b0);
        logic [7:0] bb;
        bb = b;
        dc = d;
        for (int i = 7; i >= 0; i--) spi_bit(bb[i], pop_last && (i == 0));
        sck = 1'b0;
        if (d) begin
            if (pop_last && m_fifo.size() > 0) void'(m_fifo.pop_front());
            if (m_fifo.size() < 4) m_fifo.push_back(b);
            else m_ovf = 1'b1;
            if (m_col == 7'd127) begin
                m_col = 7'd0;
                m_pg  = (m_pg == m_pe) ? m_ps : m_pg + 3'd1;
            end else begin
                m_col = m_col + 7'd1;
            end
        end else begin
            m_last = b;
            case (m_cst)
                0: if (b == 8'h22) m_cst = 1;
                1: begin m_ps = b[2:0]; m_pg = b[2:0]; m_col = 7'd0; m_cst = 2; end
                default: begin m_pe = b[2:0]; m_cst = 0; end
            endcase
        end
    endtask

    task automatic check_regs(input string tag);
        logic [7:0] v;
        reg_read(4'd0, v);
        check_eq({tag, ".head"}, v, (m_fifo.size() > 0) ? m_fifo[0] : 8'h00);
        reg_read(4'd1, v);
        check_eq({tag, ".status"}, v, {m_ovf, ~cs_n, 3'(m_fifo.size()), 3'b000});
        reg_read(4'd2, v);
`ifdef OLED_RX_CMD_DECODE_EN
        check_eq({tag, ".page"}, v, {5'b0, m_pg});
        reg_read(4'd3, v);
        check_eq({tag, ".column"}, v, {1'b0, m_col});
`else
        check_eq({tag, ".page"}, v, 8'h00);
        reg_read(4'd3, v);
        check_eq({tag, ".column"}, v, 8'h00);
`endif
        reg_read(4'd4, v);
        check_eq({tag, ".last_cmd"}, v, m_last);
        reg_read(4'd9, v);
        check_eq({tag, ".unmapped"}, v, 8'h00);
        tick();
    endtask

    task automatic drain(input string tag);
        logic [7:0] v;
        while (m_fifo.size() > 0) begin
            reg_read(4'd0, v);
            check_eq({tag, ".pop"}, v, m_fifo.pop_front());
            reg_write(4'd0, 8'h00);
        end
        reg_read(4'd1, v);
        check_eq({tag, ".drained"}, v, {m_ovf, ~cs_n, 3'b000, 3'b000});
        tick();
    endtask

    task automatic cs_cycle();
        cs_n = 1'b1;
        tick();
        tick();
        cs_n = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; dc = 1'b0;
        bus.address = 4'd0; bus.data_write = 1'b0; bus.data_in = 8'h00;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_regs("reset");

        // Single data byte
        cs_cycle();
        send_byte(8'hA5, 1'b1);
        check_regs("a5");
        check_eq("uo_out", uo_out, 8'h00);
        drain("a5");

        // Page command then 129 data bytes
        send_byte(8'h22, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h05, 1'b0);
        check_regs("pagecmd");
        for (int i = 0; i < 129; i++) send_byte(8'(i + 8'h10), 1'b1);
        check_regs("129bytes");
        drain("129bytes");
        reg_write(4'd1, 8'h01);
        m_ovf = 1'b0;
        check_regs("ovfclr1");

        // Page range of one page: 128 bytes wrap page_end back to page_start
        send_byte(8'h22, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b1);
        check_regs("pagewrap");
        reg_write(4'd1, 8'h03);
        m_fifo.delete();
        m_ovf = 1'b0;
        check_regs("flushclr");

        // Overflow with five bytes
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b1);
        check_regs("overflow");
        reg_write(4'd1, 8'h01);
        m_ovf = 1'b0;
        check_regs("ovfclr2");
        reg_write(4'd1, 8'h02);
        m_fifo.delete();
        check_regs("flush");

        // Partial byte abandoned by CS_N
        dc = 1'b1;
        for (int i = 0; i < 5; i++) spi_bit(i[0], 1'b0);
        sck = 1'b0;
        cs_cycle();
        send_byte(8'h3C, 1'b1);
        check_regs("partial");

        // Pop on the completing edge with the FIFO full
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        check_regs("full4");
        send_byte(8'h44, 1'b1, 1'b1);
        check_regs("pushpop");
        drain("pushpop");

        // Reset in the middle of a byte
        dc = 1'b1;
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0);
        sck = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        check_regs("midreset");
        for (int i = 0; i < 8; i++) spi_bit(1'b1, 1'b0);
        sck = 1'b0;
        check_regs("noarm");
        cs_cycle();
        send_byte(8'h96, 1'b1);
        check_regs("rearm");
        drain("rearm");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
